// File: rtl/palette_rgb_converter.sv
// palette_rgb_converter
// Converts a colour index into a packed {R,G,B} word using a writable palette
// RAM. The RAM is loaded with a 3-bit RGB default pattern after every reset.
// The result comes out of a 2-stage registered pipeline with valid signalling.
//
// Optional feature macro: BRIGHTNESS_EN. When it is defined, stage 2 scales
// each channel by (brightness+1)/256.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   enable     in   pipeline advance enable
//   in_valid   in   colour is valid this cycle
//   colour     in   [IDX_W]   palette index to convert
//   wr_en      in   palette write strobe
//   wr_idx     in   [IDX_W]   palette entry to write
//   wr_data    in   [3*CH_W]  new palette entry {R,G,B}
//   brightness in   [8]       global brightness (BRIGHTNESS_EN builds only)
//   rgb        out  [3*CH_W]  converted colour
//   out_valid  out  rgb holds a new valid result this cycle
//   busy       out  palette initialisation in progress
module palette_rgb_converter #(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned CH_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [IDX_W-1:0]    colour,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic [7:0]          brightness,
    output logic [3*CH_W-1:0]   rgb,
    output logic                out_valid,
    output logic                busy
);

    localparam int unsigned RGB_W = 3 * CH_W;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   init_cnt_q;
    logic [RGB_W-1:0]   pal_q [DEPTH];
    logic [RGB_W-1:0]   s1_data_q;
    logic               s1_valid_q;
    logic [RGB_W-1:0]   rgb_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               pal_we_c;
    logic [IDX_W-1:0]   pal_widx_c;
    logic [RGB_W-1:0]   pal_wdata_c;
    logic [RGB_W-1:0]   s2_data_d;

    // Default entry: index bits 2/1/0 select full-scale R/G/B.
    function automatic logic [RGB_W-1:0] default_entry(input logic [IDX_W-1:0] i);
        return {{CH_W{i[2]}}, {CH_W{i[1]}}, {CH_W{i[0]}}};
    endfunction

    // Single palette write port: the init sweep owns it until RUN.
    always_comb begin
        pal_we_c    = 1'b0;
        pal_widx_c  = wr_idx;
        pal_wdata_c = wr_data;
        if (state_q == ST_INIT) begin
            pal_we_c    = 1'b1;
            pal_widx_c  = init_cnt_q;
            pal_wdata_c = default_entry(init_cnt_q);
        end else begin
            pal_we_c    = wr_en;
        end
    end

    // Palette RAM; non-blocking write gives read-before-write on a same-index hit.
    always_ff @(posedge clk) begin
        if (rst_n && pal_we_c) begin
            pal_q[pal_widx_c] <= pal_wdata_c;
        end
    end

`ifdef BRIGHTNESS_EN
    // Per-channel (ch * (brightness+1)) >> 8.
    function automatic logic [RGB_W-1:0] scale(input logic [RGB_W-1:0] px,
                                               input logic [7:0]       b);
        logic [RGB_W-1:0]  res;
        logic [CH_W+8:0]   prod;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            prod = (CH_W+9)'(px[c*CH_W +: CH_W]) * (CH_W+9)'({1'b0, b} + 9'd1);
            res[c*CH_W +: CH_W] = CH_W'(prod >> 8);
        end
        return res;
    endfunction

    always_comb begin
        s2_data_d = scale(s1_data_q, brightness);
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;

    always_comb begin
        s2_data_d = s1_data_q;
    end
`endif

    // Control FSM and pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            busy_q      <= 1'b1;
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            rgb_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    s1_valid_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    init_cnt_q  <= init_cnt_q + IDX_W'(1);
                    if (init_cnt_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        s1_data_q   <= pal_q[colour];
                        s1_valid_q  <= in_valid;
                        rgb_q       <= s2_data_d;
                        out_valid_q <= s1_valid_q;
                    end else begin
                        // Frozen: rgb holds, but it is not a new result.
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign rgb       = rgb_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_palette_rgb_converter.sv
// tb_palette_rgb_converter
// Directed and randomised stimulus for palette_rgb_converter (IDX_W=3, CH_W=8)
// checked against a behavioural model: a palette array, a countdown for the
// initialisation sweep, and a queue of accepted colours stamped with the
// enabled-edge count at which they were captured.
// Honours BRIGHTNESS_EN in the same way as the design.
module tb_palette_rgb_converter;

    localparam int IDX_W = 3;
    localparam int CH_W  = 8;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         in_valid;
    logic [2:0]   colour;
    logic         wr_en;
    logic [2:0]   wr_idx;
    logic [23:0]  wr_data;
    logic [7:0]   brightness;
    logic [23:0]  rgb;
    logic         out_valid;
    logic         busy;

    always #5 clk = ~clk;

    palette_rgb_converter #(.IDX_W(IDX_W), .CH_W(CH_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .colour     (colour),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .brightness (brightness),
        .rgb        (rgb),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    typedef struct {
        logic [23:0] px;
        int          stamp;
    } item_t;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [23:0]  pal_m [DEPTH];
    int           init_left = DEPTH;
    int           en_cnt = 0;
    item_t        pend_q [$];
    logic         exp_ov;
    logic [23:0]  exp_rgb;
    logic         last_known = 1'b0;
    logic [23:0]  last_rgb = 24'h0;

    function automatic logic [23:0] dflt(input int i);
        logic [7:0] r, g, b;
        r = ((i >> 2) & 1) != 0 ? 8'hFF : 8'h00;
        g = ((i >> 1) & 1) != 0 ? 8'hFF : 8'h00;
        b = (i & 1) != 0 ? 8'hFF : 8'h00;
        return {r, g, b};
    endfunction

    function automatic logic [23:0] bscale(input logic [23:0] px, input logic [7:0] br);
`ifdef BRIGHTNESS_EN
        int r, g, b;
        r = (int'(px[23:16]) * (int'(br) + 1)) / 256;
        g = (int'(px[15:8])  * (int'(br) + 1)) / 256;
        b = (int'(px[7:0])   * (int'(br) + 1)) / 256;
        return {r[7:0], g[7:0], b[7:0]};
`else
        if (br == 8'h00) return px;
        return px;
`endif
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, update the model at the edge, check at negedge.
    task automatic step(input logic rn, input logic en, input logic iv,
                        input logic [2:0] col, input logic we, input logic [2:0] widx,
                        input logic [23:0] wd, input logic [7:0] br, input string tag);
        logic run;
        rst_n = rn; enable = en; in_valid = iv; colour = col;
        wr_en = we; wr_idx = widx; wr_data = wd; brightness = br;
        @(posedge clk);
        run    = rn && (init_left == 0);
        exp_ov = 1'b0;
        if (!rn) begin
            init_left  = DEPTH;
            pend_q.delete();
            for (int i = 0; i < DEPTH; i++) pal_m[i] = dflt(i);
            last_known = 1'b1;
            last_rgb   = 24'h0;
        end else if (init_left > 0) begin
            init_left--;
        end
        if (run && en) begin
            en_cnt++;
            last_known = 1'b0;
            // A result leaves on the enabled edge after the one that captured it.
            if (pend_q.size() > 0 && pend_q[0].stamp + 1 == en_cnt) begin
                exp_ov     = 1'b1;
                exp_rgb    = bscale(pend_q[0].px, br);
                last_known = 1'b1;
                last_rgb   = exp_rgb;
                void'(pend_q.pop_front());
            end
            if (iv) pend_q.push_back('{pal_m[col], en_cnt});
        end
        if (run && we) pal_m[widx] = wd;
        @(negedge clk);
        check({tag, ".busy"}, 24'(busy), 24'(init_left > 0));
        check({tag, ".out_valid"}, 24'(out_valid), 24'(exp_ov));
        if (exp_ov)
            check({tag, ".rgb"}, rgb, exp_rgb);
        else if (!(run && en) && last_known)
            check({tag, ".rgb_hold"}, rgb, last_rgb);
    endtask

    task automatic idle(input int n, input logic [7:0] br, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 24'h0, br, tag);
    endtask

    task automatic init_phase(input string tag);
        // Inputs and writes during INIT must have no effect.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b1,
                 3'($urandom_range(0, 7)), 24'($urandom), 8'hFF, tag);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 24'h0, 8'hFF, "reset");
        step(1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 24'h0, 8'hFF, "reset");
        init_phase("init");
        check("init_done.busy", 24'(busy), 24'h0);

        // Default palette sweep.
        for (int c = 0; c < DEPTH; c++)
            step(1'b1, 1'b1, 1'b1, 3'(c), 1'b0, 3'd0, 24'h0, 8'hFF, "sweep");
        idle(2, 8'hFF, "sweep_flush");

        // Same-edge read and write of entry 5.
        step(1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 3'd5, 24'h123456, 8'hFF, "rbw_old");
        step(1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 24'h0, 8'hFF, "rbw_new");
        idle(1, 8'hFF, "rbw_flush");
        check("rbw.rgb_new", rgb, 24'h123456);
        // Back-to-back writes: last wins.
        step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 24'hABCDEF, 8'hFF, "b2b_w1");
        step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 24'h0F1E2D, 8'hFF, "b2b_w2");
        step(1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 3'd0, 24'h0, 8'hFF, "b2b_rd");
        idle(1, 8'hFF, "b2b_flush");

        // Enable gap with results in flight.
        step(1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 24'h0, 8'hFF, "gap_in");
        step(1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 24'h0, 8'hFF, "gap_in");
        step(1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 24'h0, 8'hFF, "gap_in");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'b0, 3'd0, 24'h0, 8'hFF, "gap");
        idle(2, 8'hFF, "gap_resume");

        // Randomised traffic.
        for (int i = 0; i < 300; i++)
            step(1'b1, $urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)), 24'($urandom),
                 8'($urandom), "rand");
        idle(2, 8'hFF, "rand_flush");

        // Reset while streaming restores the default palette.
        step(1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 3'd5, 24'h777777, 8'hFF, "mid_stream");
        step(1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 3'd0, 24'h0, 8'hFF, "mid_stream");
        step(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 24'h0, 8'hFF, "mid_reset");
        check("mid_reset.rgb", rgb, 24'h0);
        init_phase("reinit");
        step(1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 24'h0, 8'hFF, "reinit_rd");
        idle(1, 8'hFF, "reinit_flush");
        check("reinit.entry5", rgb, 24'hFF00FF);

        // Brightness points on white (identity in the default build).
        step(1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 24'h0, 8'd127, "bright127");
        idle(1, 8'd127, "bright127");
`ifdef BRIGHTNESS_EN
        check("bright127.rgb", rgb, 24'h7F7F7F);
`else
        check("bright127.rgb", rgb, 24'hFFFFFF);
`endif
        step(1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 24'h0, 8'd255, "bright255");
        idle(1, 8'd255, "bright255");
        check("bright255.rgb", rgb, 24'hFFFFFF);
        step(1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 24'h0, 8'd0, "bright0");
        idle(1, 8'd0, "bright0");
`ifdef BRIGHTNESS_EN
        check("bright0.rgb", rgb, 24'h000000);
`else
        check("bright0.rgb", rgb, 24'hFFFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
